// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed byte stream into little-endian words, writes them to IMEM, holds core in reset until loaded.
// Define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state) before DONE.
module imem_boot_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif
  localparam logic [15:0] DEPTH = 16'(IMEM_DEPTH);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic in_ready_q, in_ready_d, we_q, we_d, core_rst_q, core_rst_d, done_q, done_d, error_q, error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic xfer;
  logic [15:0] n_hi;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign xfer = in_valid & in_ready_q;
  assign n_hi = {in_data, len_q[7:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= LEN_LO;
      len_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      LEN_LO: if (xfer) begin
        len_d[7:0] = in_data;
        state_d    = LEN_HI;
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = in_data;
        state_d     = n_hi == 16'd0 ? FIN : n_hi > DEPTH ? ERROR : DATA;
      end
      DATA: if (xfer) begin
        word_d  = {in_data, word_q[31:8]};
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? WRITE : DATA;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ in_data;
`endif
      end
      WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = cnt_q + 16'd1 >= len_q ? FIN : DATA;
      end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_d = in_data == csum_q ? DONE : ERROR;
`endif
      DONE, ERROR: if (restart) begin
        state_d = LEN_LO;
        cnt_d   = '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      default: state_d = LEN_LO;
    endcase
  end
  // Outputs are registered copies of next-state decodes, so they line up with state_q.
  always_comb begin
    in_ready_d = !(state_d inside {WRITE, DONE});
    we_d       = state_d == WRITE;
    addr_d     = state_d == WRITE ? cnt_q[ADDR_W-1:0] : state_d == LEN_LO ? '0 : addr_q;
    wdata_d    = state_d == WRITE ? word_d : wdata_q;
    core_rst_d = state_d != DONE;
    done_d     = state_d == DONE;
    error_d    = state_d == ERROR;
  end
  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign error      = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader; expected writes are queued per frame and popped on imem_we.
// Honours IMEM_BOOT_LOADER_CHECKSUM_EN by appending checksum bytes to each frame.
module tb_imem_boot_loader;
  typedef logic [7:0] bq_t[$];
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam int LAST_LAT = 1;
`else
  localparam int LAST_LAT = 2;
`endif
  logic clk = 0, rst = 0, in_valid = 0, restart = 0, fourth = 0, prev_f4 = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, core_rst, done, error;
  logic [9:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [41:0] exp_q[$];
  logic [41:0] e;
  int checks = 0, errors = 0;
  imem_boot_loader #(.IMEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  // A write must appear exactly in the cycle after a 4th data byte is accepted, and never otherwise.
  always @(negedge clk) begin
    checks++;
    if (imem_we !== prev_f4) begin
      errors++;
      $display("FAIL write_timing: imem_we=%b required %b at %0t", imem_we, prev_f4, $time);
    end
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr=%h data=%h required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write_data: addr=%h data=%h required addr=%h data=%h", imem_addr, imem_wdata, e[41:32], e[31:0]);
        end
      end
    end
    prev_f4 = in_valid & in_ready & fourth;
  end
  task automatic send_byte(input logic [7:0] b, input bit f4);
    int w = 0;
    in_data = b; in_valid = 1; fourth = f4;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 50) begin w++; @(negedge clk); end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles required 1", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 0; fourth = 0;
  endtask
  task automatic send_frame(input bq_t f, input int gap);
    int n = int'({f[1], f[0]});
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], i >= 2 && n <= 1024 && (i - 2) % 4 == 3 && (i - 2) / 4 < n);
      if (gap > 0 && i < f.size() - 1) begin repeat (gap) @(posedge clk); #1; end
    end
  endtask
  task automatic wait_end(input string name, input int lat, input logic d, input logic er);
    repeat (lat) @(negedge clk);
    checks++;
    if ({done, error, core_rst} !== {d, er, ~d}) begin
      errors++;
      $display("FAIL %s: done/error/core_rst=%b%b%b required %b%b%b", name, done, error, core_rst, d, er, ~d);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d writes missing required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 0; in_valid = 0; restart = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error} !== {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wdata=%h core_rst=%b done=%b error=%b required 0 0 000 00000000 1 0 0",
               in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error);
    end
    rst = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
  endtask
  task automatic pulse_restart();
    restart = 1; @(posedge clk); #1; restart = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, core_rst, done, error, imem_addr} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL restart: rdy=%b core_rst=%b done=%b error=%b addr=%h required 1 1 0 0 000", in_ready, core_rst, done, error, imem_addr);
    end
    @(posedge clk); #1;
  endtask
  function automatic bq_t basic_frame();
    bq_t f = '{8'h02, 8'h00, 8'hB3, 8'h01, 8'h21, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    f.push_back(8'h21);
`endif
    return f;
  endfunction
  task automatic test_basic(input string name, input int gap);
    exp_q.push_back({10'd0, 32'h002101B3});
    exp_q.push_back({10'd1, 32'h00A00113});
    send_frame(basic_frame(), gap);
    wait_end(name, LAST_LAT, 1'b1, 1'b0);
  endtask
  task automatic test_zero_len();
    bq_t f = '{8'h00, 8'h00};
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    test_reset();
    send_frame(f, 0);
    wait_end("zero_len", 1, 1'b1, 1'b0);
  endtask
  task automatic test_overflow();
    test_reset();
    send_frame('{8'h01, 8'h04}, 0);
    wait_end("overflow", 1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i * 37); in_valid = 1;
      @(negedge clk);
      checks++;
      if ({in_ready, error, core_rst} !== 3'b111) begin
        errors++;
        $display("FAIL overflow_drain%0d: rdy/error/core_rst=%b%b%b required 111", i, in_ready, error, core_rst);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    pulse_restart();
  endtask
  task automatic test_mid_reset();
    test_reset();
    send_frame('{8'h01, 8'h00, 8'hB3, 8'h01}, 0);
    test_reset();
    test_basic("after_mid_reset", 0);
  endtask
  task automatic test_full_depth();
    bq_t f = '{8'h00, 8'h04};
    logic [31:0] w;
    logic [7:0] x = 0;
    test_reset();
    for (int k = 0; k < 1024; k++) begin
      w = $urandom;
      for (int j = 0; j < 4; j++) begin f.push_back(w[8*j +: 8]); x ^= w[8*j +: 8]; end
      exp_q.push_back({10'(k), w});
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    send_frame(f, 0);
    wait_end("full_depth", LAST_LAT, 1'b1, 1'b0);
    checks++;
    if (imem_addr !== 10'd1023) begin errors++; $display("FAIL full_depth_addr: addr=%h required 3ff", imem_addr); end
  endtask
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    test_reset();
    exp_q.push_back({10'd0, 32'h44332211});
    send_frame('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 0);
    wait_end("checksum_good", 1, 1'b1, 1'b0);
    test_reset();
    exp_q.push_back({10'd0, 32'h44332211});
    send_frame('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 0);
    wait_end("checksum_bad", 1, 1'b0, 1'b1);
  endtask
`endif
  initial begin
    test_reset();
    test_basic("basic", 0);
    pulse_restart();
    test_basic("gaps", 3);
    test_zero_len();
    test_overflow();
    test_mid_reset();
    test_full_depth();
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle processor. Receives a byte stream over a valid/ready interface.
- Assembles the bytes into little-endian 32-bit instruction words and writes them sequentially into instruction memory through a write port.
- Holds the core in reset until the image is fully loaded. Replaces the simulation-only `$readmemb` preload with a synthesizable load path.

Parameters:
- IMEM_DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, word-address width (must be at least clog2(IMEM_DEPTH)).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle (transfer = in_valid & in_ready).
- restart  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  word to write.
- core_rst  output  1  reset to the processor; 1 = hold core in reset.
- done  output  1  image loaded successfully.
- error  output  1  load aborted.

Behaviour:
- Reset values (rst=0, applied asynchronously):
  - state=LEN_LO, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0.
  - Internal word count, byte index and address counter cleared.
  - in_ready goes to 1 on the first clock after reset is released.
- Frame format: 2-byte word count N (little-endian, LEN_LO first), then 4*N data bytes. Within each word, byte 0 maps to bits [7:0] and byte 3 to bits [31:24].
- States:
  - LEN_LO: accept one byte into N[7:0], then go to LEN_HI.
  - LEN_HI: accept one byte into N[15:8].
    - N==0: go to DONE.
    - N>IMEM_DEPTH: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: accept bytes and shift them into the word assembly register. On the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1 with imem_addr=current word address and imem_wdata=the assembled word; in_ready=0.
    - Then increment the address.
    - Next state: DATA if words written < N; otherwise DONE (or CHECK when the optional feature is enabled).
  - DONE: done=1, core_rst=0, in_ready=0.
  - ERROR: error=1, core_rst=1, in_ready=1. Incoming bytes are accepted and discarded so the upstream source never stalls.
- Handshake:
  - A byte is consumed only on a cycle with in_valid=1 and in_ready=1.
  - in_valid=0 stalls the FSM in its current state with no side effects. Gaps between bytes of any length are allowed.
- Outputs are registered. The write of word k occurs exactly one cycle after its 4th byte is accepted. Minimum throughput is 5 cycles per word.
- restart:
  - Honoured only in DONE or ERROR.
  - Next cycle: state=LEN_LO, core_rst=1, done=0, error=0, address=0, in_ready=1.
  - Ignored in any other state.
  - Memory contents are not cleared.
- Boundaries:
  - N==IMEM_DEPTH is legal; the final write goes to address IMEM_DEPTH-1 and the address never wraps.
  - Asserting rst mid-frame discards any partial word with no write; core_rst stays 1.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CHECK and accepts one extra byte.
  - Byte == XOR of all 4*N data bytes (length bytes excluded): go to DONE.
  - Mismatch: go to ERROR.
  - When N==0, CHECK expects 0x00.
- Undefined: the CHECK state and checksum register do not exist; the FSM goes from the last WRITE straight to DONE.

Test Plan:
- Reset, then stream 02 00 | B3 01 21 00 | 13 01 A0 00 -> writes addr0=0x002101B3 and addr1=0x00A00113, each exactly 1 cycle after its 4th byte; done=1 and core_rst=0 after the 2nd write.
- Same stream with in_valid deasserted for 3 cycles between every byte -> identical writes and data; no write occurs during any gap.
- Stream 00 00 -> no imem_we pulses; done=1 two accepts after reset (with the checksum feature enabled: after sending an additional 0x00).
- N=0x0401 with IMEM_DEPTH=1024 -> error=1, core_rst=1, no writes; 10 further bytes are all accepted (in_ready=1); a restart pulse returns to LEN_LO with error=0.
- Assert rst after 2 data bytes of word 0 -> no write; all outputs at reset values; a fresh full frame then loads correctly from addr0.
- CHECKSUM_EN: frame 01 00 | 11 22 33 44 | 44 -> DONE; the same frame with final byte 45 -> ERROR with core_rst=1.
